// File: rtl/avg_state_seq.sv
// avg_state_seq
// Vector-generator state sequencer. Owns the 4-bit state register and drives
// the address of the 256x4 registered state PROM as {halted, op, state}.
// Each step is three clocks: present address, let the PROM register it, then
// sample the PROM word. The word becomes the next state. When its top bit is
// set, the word also triggers one registered one-clock strobe.
//
// Ports
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   go         : start request, honoured only while halted
//   abort      : synchronous soft reset, highest priority
//   op[2:0]    : opcode bits from the instruction latch
//   prom_addr  : registered PROM address {halted, op, state}
//   prom_data  : PROM word, valid one clock after prom_addr changes
//   latch_stb  : one-hot pulses loading instruction bytes 0..3
//   pc_inc     : pulse coincident with any latch_stb pulse
//   pc_load    : jump target load pulse
//   draw_start : pulse starting the vector timer
//   draw_done  : vector timer idle/finished (level)
//   halted     : high while the sequencer is stopped
//   state      : current state register (debug)
module avg_state_seq #(
  parameter logic [3:0] RESET_STATE = 4'h0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic       abort,
  input  logic [2:0] op,
  output logic [7:0] prom_addr,
  input  logic [3:0] prom_data,
  output logic [3:0] latch_stb,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       draw_start,
  input  logic       draw_done,
  output logic       halted,
  output logic [3:0] state
);

  localparam logic [2:0] S_HALT = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_DRAW = 3'd4;

  logic [2:0] fsm;
  // Cleared on entry to S_DRAW. This makes draw_done be ignored in the cycle
  // while draw_start is still high, because the timer has not yet left idle.
  logic       draw_armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm        <= S_HALT;
      draw_armed <= 1'b0;
      halted     <= 1'b1;
      state      <= RESET_STATE;
      prom_addr  <= {1'b1, 3'b000, RESET_STATE};
      latch_stb  <= 4'b0000;
      pc_inc     <= 1'b0;
      pc_load    <= 1'b0;
      draw_start <= 1'b0;
    end else begin
      // Strobes default low, so each one lasts exactly one clock.
      latch_stb  <= 4'b0000;
      pc_inc     <= 1'b0;
      pc_load    <= 1'b0;
      draw_start <= 1'b0;
      if (abort) begin
        fsm        <= S_HALT;
        draw_armed <= 1'b0;
        halted     <= 1'b1;
        state      <= RESET_STATE;
        prom_addr  <= {1'b1, op, RESET_STATE};
      end else begin
        case (fsm)
          S_HALT: begin
            prom_addr <= {1'b1, op, state};
            if (go) begin
              halted <= 1'b0;
              state  <= RESET_STATE;
              fsm    <= S_ADDR;
            end
          end
          S_ADDR: begin
            // op is sampled only here, so an op change during a step waits
            // for the next step.
            prom_addr <= {1'b0, op, state};
            fsm       <= S_WAIT;
          end
          S_WAIT: begin
            fsm <= S_EXEC;
          end
          S_EXEC: begin
            state <= prom_data;
            fsm   <= S_ADDR;
            if (prom_data[3]) begin
              case (prom_data[2:0])
                3'd0, 3'd1, 3'd2, 3'd3: begin
                  latch_stb <= 4'b0001 << prom_data[1:0];
                  pc_inc    <= 1'b1;
                end
                3'd4: begin
                  draw_start <= 1'b1;
                  draw_armed <= 1'b0;
                  fsm        <= S_DRAW;
                end
                3'd5: begin
                  halted <= 1'b1;
                  fsm    <= S_HALT;
                end
                3'd6: begin
                  pc_load <= 1'b1;
                end
                default: begin
                end
              endcase
            end
          end
          S_DRAW: begin
            draw_armed <= 1'b1;
            if (draw_armed && draw_done) begin
              fsm <= S_ADDR;
            end
          end
          default: begin
            fsm <= S_HALT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avg_state_seq.sv
module tb_avg_state_seq;

  localparam logic [3:0] RS = 4'h0;

  logic       clk;
  logic       reset_n;
  logic       go;
  logic       abort;
  logic [2:0] op;
  logic [7:0] prom_addr;
  logic [3:0] prom_data;
  logic [3:0] latch_stb;
  logic       pc_inc;
  logic       pc_load;
  logic       draw_start;
  logic       draw_done;
  logic       halted;
  logic [3:0] state;

  avg_state_seq #(.RESET_STATE(RS)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .abort(abort), .op(op),
    .prom_addr(prom_addr), .prom_data(prom_data), .latch_stb(latch_stb),
    .pc_inc(pc_inc), .pc_load(pc_load), .draw_start(draw_start),
    .draw_done(draw_done), .halted(halted), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered state PROM.
  logic [3:0] rom [0:255];
  always @(posedge clk) prom_data <= rom[prom_addr];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model. Step position: -1 halted, 0..2 the three clocks of a
  // step, 3 waiting on the vector timer.
  int         m_ph;
  int         m_dw;
  logic       m_halted;
  logic [3:0] m_state;
  logic [7:0] m_addr;
  logic [3:0] m_pdata;
  logic [3:0] m_lstb;
  logic       m_inc, m_load, m_ds;

  int         n_ph, n_dw;
  logic       n_halted;
  logic [3:0] n_state, n_lstb, w;
  logic [7:0] n_addr;
  logic       n_inc, n_load, n_ds;

  always @(posedge clk) m_pdata <= rom[m_addr];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph <= -1; m_dw <= 0; m_halted <= 1'b1; m_state <= RS;
      m_addr <= {1'b1, 3'b000, RS};
      m_lstb <= 4'b0; m_inc <= 1'b0; m_load <= 1'b0; m_ds <= 1'b0;
    end else begin
      n_ph = m_ph; n_dw = m_dw; n_halted = m_halted; n_state = m_state;
      n_addr = m_addr;
      n_lstb = 4'b0; n_inc = 1'b0; n_load = 1'b0; n_ds = 1'b0;
      if (abort) begin
        n_ph = -1; n_halted = 1'b1; n_state = RS; n_addr = {1'b1, op, RS};
      end else if (m_ph == -1) begin
        n_addr = {1'b1, op, m_state};
        if (go) begin n_halted = 1'b0; n_state = RS; n_ph = 0; end
      end else if (m_ph == 0) begin
        n_addr = {1'b0, op, m_state}; n_ph = 1;
      end else if (m_ph == 1) begin
        n_ph = 2;
      end else if (m_ph == 2) begin
        w = m_pdata;
        n_state = w;
        n_ph = 0;
        if (w[3]) begin
          if (w[2] == 1'b0) begin
            n_lstb[w[1:0]] = 1'b1; n_inc = 1'b1;
          end else if (w[2:0] == 3'd4) begin
            n_ds = 1'b1; n_ph = 3; n_dw = 0;
          end else if (w[2:0] == 3'd5) begin
            n_halted = 1'b1; n_ph = -1;
          end else if (w[2:0] == 3'd6) begin
            n_load = 1'b1;
          end
        end
      end else begin
        if (m_dw >= 1 && draw_done) n_ph = 0;
        n_dw = m_dw + 1;
      end
      m_ph <= n_ph; m_dw <= n_dw; m_halted <= n_halted; m_state <= n_state;
      m_addr <= n_addr; m_lstb <= n_lstb; m_inc <= n_inc; m_load <= n_load;
      m_ds <= n_ds;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if ({halted, state, prom_addr, latch_stb, pc_inc, pc_load, draw_start} !==
          {m_halted, m_state, m_addr, m_lstb, m_inc, m_load, m_ds}) begin
        n_fail++;
        $display("FAIL model t=%0t got h=%b s=%h a=%h l=%b i=%b p=%b d=%b want h=%b s=%h a=%h l=%b i=%b p=%b d=%b",
                 $time, halted, state, prom_addr, latch_stb, pc_inc, pc_load, draw_start,
                 m_halted, m_state, m_addr, m_lstb, m_inc, m_load, m_ds);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; go = 1'b0; abort = 1'b0; op = 3'd0; draw_done = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 4'h0;
    rom[8'h00] = 4'h7; rom[8'h07] = 4'h0; rom[8'h10] = 4'hB; rom[8'h1B] = 4'hD;
    rom[8'h1D] = 4'h0; rom[8'h20] = 4'hC; rom[8'h2C] = 4'h0;
    tick(3);
    chk_en = 1'b1;
    chk("rst_halted", halted, 1);
    chk("rst_addr", prom_addr, 8'h80);
    chk("rst_state", state, 0);
    chk("rst_strobes", {latch_stb, pc_inc, pc_load, draw_start}, 0);
    reset_n = 1'b1;
    tick(20);
    chk("idle20_addr", prom_addr, 8'h80);
    chk("idle20_halted", halted, 1);

    // Idle loop 0 -> 7 -> 0 -> 7.
    pulse_go();
    tick(3); chk("loop_s7a", state, 4'h7); chk("loop_halted", halted, 0);
    tick(3); chk("loop_s0", state, 4'h0);
    tick(3); chk("loop_s7b", state, 4'h7);
    chk("loop_strobes", {latch_stb, pc_inc, pc_load, draw_start}, 0);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("abort_halted", halted, 1); chk("abort_addr", prom_addr, 8'h80);

    // Latch then halt.
    op = 3'd1;
    pulse_go();
    tick(3); chk("latch_stb", latch_stb, 4'b1000); chk("latch_inc", pc_inc, 1);
    chk("latch_state", state, 4'hB);
    tick(1); chk("latch_end", {latch_stb, pc_inc}, 0); chk("latch_addr", prom_addr, 8'h1B);
    tick(2); chk("halt_halted", halted, 1); chk("halt_state", state, 4'hD);
    chk("halt_addr_hold", prom_addr, 8'h1B);
    tick(1); chk("halt_addr", prom_addr, 8'h9D);
    pulse_go();
    tick(3); chk("restart_state", state, 4'hB); chk("restart_stb", latch_stb, 4'b1000);
    tick(3); chk("restart_halt", halted, 1);

    // Draw handshake.
    op = 3'd2; draw_done = 1'b0;
    pulse_go();
    tick(3); chk("draw_start", draw_start, 1); chk("draw_state", state, 4'hC);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chk("draw_hold_addr", prom_addr, 8'h20);
      chk("draw_single", draw_start, 0);
    end
    draw_done = 1'b1;
    tick(1); chk("draw_done_addr_hold", prom_addr, 8'h20);
    tick(1); chk("draw_next_addr", prom_addr, 8'h2C);
    tick(5); chk("draw2_start", draw_start, 1); chk("draw2_state", state, 4'hC);

    // Reset mid-draw.
    reset_n = 1'b0; #1;
    chk("midrst_halted", halted, 1); chk("midrst_state", state, 0);
    chk("midrst_strobes", {latch_stb, pc_inc, pc_load, draw_start}, 0);
    chk("midrst_addr", prom_addr, 8'h80);
    tick(2); reset_n = 1'b1;
    tick(5);
    chk("postrst_quiet", {halted, latch_stb, pc_inc, pc_load, draw_start}, 8'h80);
    draw_done = 1'b0;

    // go while running is ignored.
    op = 3'd0;
    go = 1'b1; tick(1); tick(1); go = 1'b0;
    tick(2); chk("gorun_s7", state, 4'h7);
    tick(3); chk("gorun_s0", state, 4'h0);
    abort = 1'b1; tick(1); abort = 1'b0;

    // go and abort together: abort wins.
    go = 1'b1; abort = 1'b1; tick(1); go = 1'b0; abort = 1'b0;
    chk("goabort_halted", halted, 1);
    tick(3); chk("goabort_stay", {halted, prom_addr[7]}, 2'b11);

    // Randomised run with a random PROM.
    for (int i = 0; i < 256; i++) rom[i] = 4'($urandom_range(0, 15));
    for (int c = 0; c < 4000; c++) begin
      if (m_halted) op = 3'($urandom_range(0, 7));
      go = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 63) == 0);
      draw_done = $urandom_range(0, 1) == 1;
      reset_n = !(c == 2000 || c == 2001);
      tick(1);
    end
    go = 1'b0; abort = 1'b0; reset_n = 1'b1;
    tick(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
